// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin arbiter feeding one shared two-stage registered adder
// Ports: clk/reset (sync, active-high); sched_en gates new grants;
//   req_valid/req_a/req_b per-requester requests, operands packed at [i*ADDER_WIDTH +: ADDER_WIDTH];
//   req_ready one-hot-or-zero combinational grant;
//   rsp_valid/rsp_id/rsp_sum registered result tagged with requester index.
// Optional: define SHARED_ADDER_STATS_EN to add grant_count, saturating 16-bit per-requester transfer counters.
module shared_adder_arbiter #(
  parameter int ADDER_WIDTH = 114,
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sched_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [ADDER_WIDTH:0]           rsp_sum
`ifdef SHARED_ADDER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          grant_count
`endif
);
  logic [ID_WIDTH-1:0] ptr, g, id1;
  logic hit, go, v1;
  logic [ADDER_WIDTH-1:0] a_reg, b_reg;
  // scan from the farthest offset down so the nearest valid index at or after ptr wins
  always_comb begin
    g = '0;
    hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        g = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign go = hit && sched_en && !reset;
  assign req_ready = go ? NUM_REQ'(1) << g : '0;
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      v1 <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      id1 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
    end else begin
      v1 <= go;
      rsp_valid <= v1;
      if (go) begin
        ptr <= (g == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        a_reg <= req_a[int'(g)*ADDER_WIDTH +: ADDER_WIDTH];
        b_reg <= req_b[int'(g)*ADDER_WIDTH +: ADDER_WIDTH];
        id1 <= g;
      end
      // result registers hold their last value when no op is in stage 1
      if (v1) begin
        rsp_sum <= {1'b0, a_reg} + {1'b0, b_reg};
        rsp_id <= id1;
      end
    end
`ifdef SHARED_ADDER_STATS_EN
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (reset) grant_count[i*16 +: 16] <= '0;
      else if (req_ready[i] && grant_count[i*16 +: 16] != 16'hFFFF)
        grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: table-driven and directed checks of the shared adder arbiter
module tb_shared_adder_arbiter;
  localparam int AW = 114;
  localparam logic H = 1'b1, L = 1'b0;
  typedef struct {
    logic rst, en;
    logic [3:0] v, rdy;
    logic rv;
    logic [1:0] id;
    logic [AW:0] sum;
  } vec_t;
  logic clk, reset, sched_en, rsp_valid;
  logic [3:0] req_valid, req_ready;
  logic [4*AW-1:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [AW:0] rsp_sum, e1, e2;
  logic [AW-1:0] opa [4], opb [4];
`ifdef SHARED_ADDER_STATS_EN
  logic [63:0] grant_count;
`endif
  int chk_cnt = 0, pass_cnt = 0, rule_fail = 0;
  vec_t tbl [25];
  logic [3:0] pend = '0;
  logic [4*AW-1:0] pa, pb;

  shared_adder_arbiter #(.ADDER_WIDTH(AW), .NUM_REQ(4), .ID_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef SHARED_ADDER_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*AW +: AW] = opa[i];
      req_b[i*AW +: AW] = opb[i];
    end
  end

  // requester rule: a pending request must keep valid and operands until it is granted
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pend[i] && (!req_valid[i] || req_a[i*AW +: AW] != pa[i*AW +: AW] || req_b[i*AW +: AW] != pb[i*AW +: AW])) begin
        $display("FAIL requester_rule: requester %0d changed before grant", i);
        rule_fail++;
      end
    pend <= reset ? 4'b0 : req_valid & ~req_ready;
    pa <= req_a;
    pb <= req_b;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, e, input logic [3:0] v, rd, input logic rv, input logic [1:0] id, input logic [AW:0] s);
    mk.rst = r; mk.en = e; mk.v = v; mk.rdy = rd; mk.rv = rv; mk.id = id; mk.sum = s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic cyc(input logic r, e, input logic [3:0] v);
    @(negedge clk);
    reset = r;
    sched_en = e;
    req_valid = v;
    #1;
  endtask

  initial begin
    reset = 1'b1; sched_en = 1'b1; req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = AW'(100 * (i + 1));
      opb[i] = AW'(i + 1);
    end
    e1 = {1'b1, {(AW-1){1'b1}}, 1'b0};
    e2 = (AW+1)'(1) << AW;
    tbl[0]  = mk(H, H, 4'b1111, 4'b0000, L, 2'd0, 115'd0);
    tbl[1]  = mk(L, H, 4'b1111, 4'b0001, L, 2'd0, 115'd0);
    tbl[2]  = mk(L, H, 4'b1111, 4'b0010, L, 2'd0, 115'd0);
    tbl[3]  = mk(L, H, 4'b1111, 4'b0100, H, 2'd0, 115'd101);
    tbl[4]  = mk(L, H, 4'b1111, 4'b1000, H, 2'd1, 115'd202);
    tbl[5]  = mk(L, H, 4'b1111, 4'b0001, H, 2'd2, 115'd303);
    tbl[6]  = mk(L, H, 4'b1110, 4'b0010, H, 2'd3, 115'd404);
    tbl[7]  = mk(L, H, 4'b1100, 4'b0100, H, 2'd0, 115'd101);
    tbl[8]  = mk(L, H, 4'b1000, 4'b1000, H, 2'd1, 115'd202);
    tbl[9]  = mk(L, H, 4'b0100, 4'b0100, H, 2'd2, 115'd303);
    tbl[10] = mk(L, H, 4'b0101, 4'b0001, H, 2'd3, 115'd404);
    tbl[11] = mk(L, H, 4'b0101, 4'b0100, H, 2'd2, 115'd303);
    tbl[12] = mk(L, H, 4'b0001, 4'b0001, H, 2'd0, 115'd101);
    tbl[13] = mk(L, H, 4'b1000, 4'b1000, H, 2'd2, 115'd303);
    tbl[14] = mk(L, H, 4'b0100, 4'b0100, H, 2'd0, 115'd101);
    tbl[15] = mk(L, L, 4'b1111, 4'b0000, H, 2'd3, 115'd404);
    tbl[16] = mk(L, L, 4'b1111, 4'b0000, H, 2'd2, 115'd303);
    tbl[17] = mk(L, L, 4'b1111, 4'b0000, L, 2'd2, 115'd303);
    tbl[18] = mk(L, H, 4'b1111, 4'b1000, L, 2'd2, 115'd303);
    tbl[19] = mk(L, H, 4'b0111, 4'b0001, L, 2'd2, 115'd303);
    tbl[20] = mk(L, H, 4'b0110, 4'b0010, H, 2'd3, 115'd404);
    tbl[21] = mk(L, H, 4'b0100, 4'b0100, H, 2'd0, 115'd101);
    tbl[22] = mk(L, H, 4'b0000, 4'b0000, H, 2'd1, 115'd202);
    tbl[23] = mk(L, H, 4'b0000, 4'b0000, H, 2'd2, 115'd303);
    tbl[24] = mk(L, H, 4'b0000, 4'b0000, L, 2'd2, 115'd303);
    cyc(H, H, 4'b0000);
    cyc(H, H, 4'b0000);
    for (int r = 0; r < 25; r++) begin
      cyc(tbl[r].rst, tbl[r].en, tbl[r].v);
      chk($sformatf("ready_r%0d", r), req_ready, tbl[r].rdy);
      chk($sformatf("rsp_valid_r%0d", r), rsp_valid, tbl[r].rv);
      chk($sformatf("rsp_id_r%0d", r), rsp_id, tbl[r].id);
      chk($sformatf("rsp_sum_r%0d", r), rsp_sum, tbl[r].sum);
    end
    // basic latency: 5 + 7 from requester 0 right after reset
    opa[0] = AW'(5);
    opb[0] = AW'(7);
    cyc(H, H, 4'b0000);
    cyc(L, H, 4'b0001);
    chk("basic_ready", req_ready, 4'b0001);
    chk("basic_reset_sum", rsp_sum, 0);
    cyc(L, H, 4'b0000);
    chk("basic_t1_valid", rsp_valid, 0);
    cyc(L, H, 4'b0000);
    chk("basic_t2_valid", rsp_valid, 1);
    chk("basic_t2_id", rsp_id, 0);
    chk("basic_t2_sum", rsp_sum, 12);
    cyc(L, H, 4'b0000);
    chk("basic_t3_valid", rsp_valid, 0);
    chk("basic_t3_hold", rsp_sum, 12);
    // carry-out, with requester 1 granted on consecutive cycles
    opa[1] = '1;
    opb[1] = '1;
    cyc(L, H, 4'b0010);
    chk("carry_ready1", req_ready, 4'b0010);
    @(posedge clk);
    #1 opb[1] = AW'(1);
    cyc(L, H, 4'b0010);
    chk("carry_ready2", req_ready, 4'b0010);
    cyc(L, H, 4'b0000);
    chk("carry1_valid", rsp_valid, 1);
    chk("carry1_id", rsp_id, 1);
    chk("carry1_sum", rsp_sum, e1);
    cyc(L, H, 4'b0000);
    chk("carry2_valid", rsp_valid, 1);
    chk("carry2_sum", rsp_sum, e2);
    // reset the cycle after a grant discards the op
    opa[2] = AW'(3);
    opb[2] = AW'(4);
    cyc(L, H, 4'b0100);
    chk("rst_grant", req_ready, 4'b0100);
    cyc(H, H, 4'b0011);
    chk("rst_ready_zero", req_ready, 4'b0000);
    cyc(L, H, 4'b0110);
    chk("rst_lowest", req_ready, 4'b0010);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_sum", rsp_sum, 0);
`ifdef SHARED_ADDER_STATS_EN
    chk("gc_reset", grant_count, 64'd0);
`endif
    cyc(L, H, 4'b0100);
    chk("rst_next_ready", req_ready, 4'b0100);
    chk("rst_no_ghost", rsp_valid, 0);
    cyc(L, H, 4'b0000);
    chk("post_rst1_valid", rsp_valid, 1);
    chk("post_rst1_id", rsp_id, 1);
    chk("post_rst1_sum", rsp_sum, e2);
    cyc(L, H, 4'b0000);
    chk("post_rst2_valid", rsp_valid, 1);
    chk("post_rst2_id", rsp_id, 2);
    chk("post_rst2_sum", rsp_sum, 7);
    cyc(L, H, 4'b0000);
    chk("post_rst_idle", rsp_valid, 0);
`ifdef SHARED_ADDER_STATS_EN
    chk("gc_final", grant_count, {16'd0, 16'd1, 16'd1, 16'd0});
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + rule_fail);
    $finish;
  end
endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
- Shares one registered wide adder (ADDER_WIDTH-bit operands, ADDER_WIDTH+1-bit sum) between NUM_REQ requesters.
- Round-robin arbiter grants one operand pair per cycle into a 2-stage pipeline (operand register, sum register).
- Each result is returned tagged with the requester index.
- Sits between multiple arithmetic clients and the single adder instance in the arithmetic benchmark designs.

Parameters:
- ADDER_WIDTH, 114, operand width in bits; sum is ADDER_WIDTH+1.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of requester tag; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- sched_en  input  1  when low no new grants are issued; pipeline keeps draining.
- req_valid  input  NUM_REQ  per-requester request.
- req_a  input  NUM_REQ*ADDER_WIDTH  packed operand A; requester i at [i*ADDER_WIDTH +: ADDER_WIDTH].
- req_b  input  NUM_REQ*ADDER_WIDTH  packed operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot-or-zero grant, combinational.
- rsp_valid  output  1  registered; result valid this cycle.
- rsp_id  output  ID_WIDTH  registered; requester index of the result.
- rsp_sum  output  ADDER_WIDTH+1  registered; a+b including carry-out.

Behaviour:
- Handshake:
  - Transfer from requester i occurs in cycle T when req_valid[i] && req_ready[i].
  - req_ready is one-hot or zero; no backpressure exists on the response side.
- Arbitration (combinational):
  - Among asserted req_valid bits, grant the first index >= ptr, wrapping modulo NUM_REQ.
  - No grant when sched_en=0, reset=1, or no valid requests.
- Pointer update:
  - On a transfer to index g, ptr <= (g+1) mod NUM_REQ. Wrap: g=NUM_REQ-1 gives ptr 0.
  - Without a transfer, ptr holds.
- Requester rule: once req_valid[i] is asserted, it and the operands stay stable until the transfer. A bench assertion flags a drop or change before req_ready.
- Stage 1 (posedge ending cycle T): a_reg, b_reg <= granted operands; id1 <= g; v1 <= transfer.
- Stage 2 (next posedge): rsp_sum <= a_reg + b_reg (full ADDER_WIDTH+1 bits, unsigned, carry in MSB); rsp_id <= id1; rsp_valid <= v1.
- Latency and throughput:
  - Transfer in cycle T gives rsp_valid=1 in cycle T+2.
  - Throughput is 1 op/cycle; back-to-back grants yield back-to-back responses in grant order.
- Data gating: when v1=0, the rsp_sum/rsp_id registers hold their previous values; rsp_valid=0.
- Reset (synchronous, dominates all else):
  - ptr=0; v1=0; rsp_valid=0; rsp_id=0; rsp_sum=0; a_reg=b_reg=0; id1=0.
  - Reset asserted mid-operation discards all in-flight ops; no response is ever produced for them.
  - req_ready=0 while reset=1.
- Simultaneous events:
  - sched_en falling in the same cycle as a pending request: no grant that cycle; ptr unchanged.
  - A requester whose response is emerging may be granted again in the same cycle.
- Single requester continuously valid: granted every cycle.

Optional Feature:
- Macro: SHARED_ADDER_STATS_EN.
- Defined: adds output grant_count, NUM_REQ*16 bits, requester i at [i*16 +: 16].
  - Each counter increments by 1 on every transfer from that requester.
  - Counters saturate at 16'hFFFF.
  - Counters clear to 0 on reset.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset, then req_valid=4'b0001, a=5, b=7 -> req_ready=4'b0001 in cycle T; cycle T+2: rsp_valid=1, rsp_id=0, rsp_sum=12; cycle T+3: rsp_valid=0.
- Carry-out: a=b=2^114-1 -> rsp_sum=2^115-2 (bit 114 set, bit 0 clear); a=2^114-1, b=1 -> rsp_sum=2^114.
- Fairness: all four requesters valid continuously with distinct operands -> grants 0,1,2,3,0,1 on consecutive cycles; responses in the same order, one per cycle starting 2 cycles after the first grant.
- Wrap and skip: ptr=3 after granting 2, req_valid=4'b0101 -> grant 0, then 2; with ptr=1 and req_valid=4'b1000 -> grant 3, ptr becomes 0.
- sched_en=0 with req_valid=4'b1111 for 3 cycles -> req_ready=0, ptr unchanged; in-flight ops from before still complete on schedule.
- Reset asserted the cycle after a grant -> no rsp_valid ever appears for that op; all outputs 0; the first grant after reset goes to the lowest valid index. With SHARED_ADDER_STATS_EN defined, grant_count is all zero after reset and counts exactly the transfers afterwards.
